// File: rtl/decode_stage.sv
// ID stage: register file read with write-first bypass, control decode, JMP/BC
// resolution, RAW interlock against EX/MEM, and wrong-path squash after a taken branch.
module decode_stage #(
  parameter int          FLUSH_SLOTS = 2,
  parameter logic [31:0] REG_RESET   = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ins,
  input  logic [31:0] pc,
  input  logic        ex_we,
  input  logic [4:0]  ex_rd,
  input  logic        mem_we,
  input  logic [4:0]  mem_rd,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        br,
  output logic [31:0] br_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_a,
  output logic [31:0] id_b,
  output logic [31:0] id_imm,
  output logic [1:0]  id_alu_op,
  output logic        id_use_imm,
  output logic        id_we,
  output logic [4:0]  id_rd,
  output logic        id_illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_MVI   = 6'b001001;
  localparam logic [5:0] OP_JMP   = 6'b000010;
  localparam logic [5:0] OP_BC    = 6'b000011;
  localparam logic [5:0] FN_NOP   = 6'b000000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_MOV   = 6'b101000;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_SUB    = 2'd1;
  localparam logic [1:0] ALU_PASS_B = 2'd2;

  localparam logic [1:0] FLUSH_CNT = 2'(FLUSH_SLOTS);

  logic [31:0] regs_q [32];
  logic [1:0]  squash_q, squash_d;
  logic        br_q, br_d;
  logic [31:0] br_pc_q, br_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_a_q, id_a_d;
  logic [31:0] id_b_q, id_b_d;
  logic [31:0] id_imm_q, id_imm_d;
  logic [1:0]  id_alu_op_q, id_alu_op_d;
  logic        id_use_imm_q, id_use_imm_d;
  logic        id_we_q, id_we_d;
  logic [4:0]  id_rd_q, id_rd_d;
  logic        id_illegal_q, id_illegal_d;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_ext, rs_val, rt_val, target;
  logic        dec_we, dec_use_imm, dec_illegal, dec_rtype, dec_jmp, dec_bc;
  logic [4:0]  dec_dest;
  logic [1:0]  dec_alu;
  logic        we_eff, rs_hit, rt_hit, squashing, hazard, issue, taken;

  assign op      = ins[31:26];
  assign rs      = ins[25:21];
  assign rt      = ins[20:16];
  assign rd      = ins[15:11];
  assign funct   = ins[5:0];
  assign imm_ext = {{16{ins[15]}}, ins[15:0]};

  // Write-first bypass so an instruction in ID sees the value retiring this cycle.
  assign rs_val = (rs == 5'd0) ? 32'd0 :
                  (wb_we && wb_rd == rs) ? wb_data : regs_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 :
                  (wb_we && wb_rd == rt) ? wb_data : regs_q[rt];

  always_comb begin
    dec_we      = 1'b0;
    dec_dest    = 5'd0;
    dec_alu     = ALU_ADD;
    dec_use_imm = 1'b0;
    dec_illegal = 1'b0;
    dec_rtype   = 1'b0;
    dec_jmp     = 1'b0;
    dec_bc      = 1'b0;
    case (op)
      OP_RTYPE: begin
        dec_rtype = 1'b1;
        case (funct)
          FN_ADD:  begin dec_we = 1'b1; dec_dest = rd; end
          FN_SUB:  begin dec_we = 1'b1; dec_dest = rd; dec_alu = ALU_SUB; end
          FN_MOV:  begin dec_we = 1'b1; dec_dest = rd; dec_alu = ALU_PASS_B; end
          FN_NOP:  ;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_MVI: begin
        dec_we      = 1'b1;
        dec_dest    = rt;
        dec_use_imm = 1'b1;
      end
      OP_JMP:  dec_jmp = 1'b1;
      OP_BC:   dec_bc = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
  end

  assign we_eff    = dec_we && (dec_dest != 5'd0);
  assign rs_hit    = (rs != 5'd0) && ((ex_we && ex_rd == rs) || (mem_we && mem_rd == rs));
  assign rt_hit    = (rt != 5'd0) && ((ex_we && ex_rd == rt) || (mem_we && mem_rd == rt));
  assign squashing = (squash_q != 2'd0);
  // A squashed slot is discarded anyway, so it must never hold fetch.
  assign hazard    = !squashing && (rs_hit || (dec_rtype && rt_hit));
  assign issue     = !squashing && !hazard;
  assign taken     = issue && (dec_jmp || (dec_bc && rs_val[31]));
  assign target    = dec_jmp ? {6'b0, ins[25:0]} : pc + imm_ext;
  assign stall     = !rst && hazard;

  always_comb begin
    squash_d     = squashing ? squash_q - 2'd1 : (taken ? FLUSH_CNT : 2'd0);
    br_d         = taken;
    br_pc_d      = taken ? target : 32'd0;
    id_valid_d   = 1'b0;
    id_pc_d      = 32'd0;
    id_a_d       = 32'd0;
    id_b_d       = 32'd0;
    id_imm_d     = 32'd0;
    id_alu_op_d  = ALU_ADD;
    id_use_imm_d = 1'b0;
    id_we_d      = 1'b0;
    id_rd_d      = 5'd0;
    id_illegal_d = 1'b0;
    if (issue) begin
      id_valid_d   = 1'b1;
      id_pc_d      = pc;
      id_a_d       = rs_val;
      id_b_d       = rt_val;
      id_imm_d     = imm_ext;
      id_alu_op_d  = dec_alu;
      id_use_imm_d = dec_use_imm;
      id_we_d      = we_eff;
      id_rd_d      = we_eff ? dec_dest : 5'd0;
      id_illegal_d = dec_illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= (i == 0) ? 32'd0 : REG_RESET;
      end
    end else if (wb_we && wb_rd != 5'd0) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      squash_q     <= 2'd0;
      br_q         <= 1'b0;
      br_pc_q      <= 32'd0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= 32'd0;
      id_a_q       <= 32'd0;
      id_b_q       <= 32'd0;
      id_imm_q     <= 32'd0;
      id_alu_op_q  <= ALU_ADD;
      id_use_imm_q <= 1'b0;
      id_we_q      <= 1'b0;
      id_rd_q      <= 5'd0;
      id_illegal_q <= 1'b0;
    end else begin
      squash_q     <= squash_d;
      br_q         <= br_d;
      br_pc_q      <= br_pc_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_a_q       <= id_a_d;
      id_b_q       <= id_b_d;
      id_imm_q     <= id_imm_d;
      id_alu_op_q  <= id_alu_op_d;
      id_use_imm_q <= id_use_imm_d;
      id_we_q      <= id_we_d;
      id_rd_q      <= id_rd_d;
      id_illegal_q <= id_illegal_d;
    end
  end

  assign br         = br_q;
  assign br_pc      = br_pc_q;
  assign id_valid   = id_valid_q;
  assign id_pc      = id_pc_q;
  assign id_a       = id_a_q;
  assign id_b       = id_b_q;
  assign id_imm     = id_imm_q;
  assign id_alu_op  = id_alu_op_q;
  assign id_use_imm = id_use_imm_q;
  assign id_we      = id_we_q;
  assign id_rd      = id_rd_q;
  assign id_illegal = id_illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: each step pushes its expected ID/EX contents to a
// scoreboard queue, and the entry is popped and compared once the DUT has clocked it in.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins, pc;
  logic        ex_we, mem_we, wb_we;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic [31:0] wb_data;
  logic        stall, br, id_valid, id_use_imm, id_we, id_illegal;
  logic [31:0] br_pc, id_pc, id_a, id_b, id_imm;
  logic [1:0]  id_alu_op;
  logic [4:0]  id_rd;

  localparam logic [31:0] RR = 32'h0000_0011;

  decode_stage #(.FLUSH_SLOTS(2), .REG_RESET(RR)) dut (
    .clk(clk), .rst(rst), .ins(ins), .pc(pc),
    .ex_we(ex_we), .ex_rd(ex_rd), .mem_we(mem_we), .mem_rd(mem_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .br(br), .br_pc(br_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_use_imm(id_use_imm), .id_we(id_we), .id_rd(id_rd),
    .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, we, use_imm, illegal, br, full;
    logic [4:0]  rd;
    logic [1:0]  alu;
    logic [31:0] pc, imm, a, b, br_pc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] rtype(input logic [4:0] d, input logic [4:0] s,
                                        input logic [4:0] t, input logic [5:0] fn);
    return {6'b000000, s, t, d, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {o, s, t, im};
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e = '{valid: 1'b0, we: 1'b0, use_imm: 1'b0, illegal: 1'b0, br: 1'b0, full: 1'b0,
          rd: 5'd0, alu: 2'd0, pc: 32'd0, imm: 32'd0, a: 32'd0, b: 32'd0, br_pc: 32'd0};
    return e;
  endfunction

  // Issued instruction, all fields checked.
  function automatic exp_t full_exp(input logic [31:0] p, input logic we, input logic [4:0] rd,
                                    input logic [1:0] alu, input logic ui, input logic [31:0] imm,
                                    input logic [31:0] a, input logic [31:0] b, input logic ill);
    exp_t e;
    e = bubble();
    e.valid = 1'b1; e.full = 1'b1; e.pc = p; e.we = we; e.rd = rd; e.alu = alu;
    e.use_imm = ui; e.imm = imm; e.a = a; e.b = b; e.illegal = ill;
    return e;
  endfunction

  // Issued branch: only control and redirect checked.
  function automatic exp_t br_exp(input logic tk, input logic [31:0] tgt);
    exp_t e;
    e = bubble();
    e.valid = 1'b1; e.br = tk; e.br_pc = tgt;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    assert (got === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, expv);
    end
  endtask

  task automatic step(input string name, input logic [31:0] i_w, input logic [31:0] p,
                      input logic exp_stall, input exp_t e);
    exp_t g;
    ins = i_w;
    pc  = p;
    sb.push_back(e);
    #1;
    chk({name, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
    @(posedge clk);
    #1;
    g = sb.pop_front();
    $display("step %-10s ins=%h pc=%0d -> valid=%0d we=%0d rd=%0d br=%0d br_pc=%0d ill=%0d",
             name, i_w, p, id_valid, id_we, id_rd, br, br_pc, id_illegal);
    chk({name, ".valid"},   {31'd0, id_valid},   {31'd0, g.valid});
    chk({name, ".we"},      {31'd0, id_we},      {31'd0, g.we});
    chk({name, ".rd"},      {27'd0, id_rd},      {27'd0, g.rd});
    chk({name, ".illegal"}, {31'd0, id_illegal}, {31'd0, g.illegal});
    chk({name, ".br"},      {31'd0, br},         {31'd0, g.br});
    if (g.br) chk({name, ".br_pc"}, br_pc, g.br_pc);
    if (g.full) begin
      chk({name, ".pc"},      id_pc,               g.pc);
      chk({name, ".alu"},     {30'd0, id_alu_op},  {30'd0, g.alu});
      chk({name, ".use_imm"}, {31'd0, id_use_imm}, {31'd0, g.use_imm});
      chk({name, ".imm"},     id_imm,              g.imm);
      chk({name, ".a"},       id_a,                g.a);
      chk({name, ".b"},       id_b,                g.b);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, ".br"},      {31'd0, br},         32'd0);
    chk({name, ".br_pc"},   br_pc,               32'd0);
    chk({name, ".valid"},   {31'd0, id_valid},   32'd0);
    chk({name, ".we"},      {31'd0, id_we},      32'd0);
    chk({name, ".illegal"}, {31'd0, id_illegal}, 32'd0);
    chk({name, ".a"},       id_a,                32'd0);
    chk({name, ".stall"},   {31'd0, stall},      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ins = rtype(5'd4, 5'd4, 5'd1, 6'b100010); pc = 32'd0;
    ex_we = 1'b1; ex_rd = 5'd4; mem_we = 1'b0; mem_rd = 5'd0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    #2;
    chk("rst.stall_gated", {31'd0, stall}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0; ex_we = 1'b0; ex_rd = 5'd0;

    step("mvi_r1", itype(6'b001001, 5'd0, 5'd1, 16'd4), 32'd0, 1'b0,
         full_exp(32'd0, 1'b1, 5'd1, 2'd0, 1'b1, 32'd4, 32'd0, RR, 1'b0));

    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd4;
    step("nop_wb1", 32'd0, 32'd1, 1'b0,
         full_exp(32'd1, 1'b0, 5'd0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0));

    wb_rd = 5'd2; wb_data = 32'd55;
    step("mov_byp", rtype(5'd4, 5'd0, 5'd2, 6'b101000), 32'd2, 1'b0,
         full_exp(32'd2, 1'b1, 5'd4, 2'd2, 1'b0, 32'h2028, 32'd0, 32'd55, 1'b0));
    wb_we = 1'b0;

    ex_we = 1'b1; ex_rd = 5'd4;
    step("sub_exhaz", rtype(5'd4, 5'd4, 5'd1, 6'b100010), 32'd3, 1'b1, bubble());
    ex_we = 1'b0; mem_we = 1'b1; mem_rd = 5'd1;
    step("sub_memhaz", rtype(5'd4, 5'd4, 5'd1, 6'b100010), 32'd3, 1'b1, bubble());
    mem_we = 1'b0;
    step("sub_issue", rtype(5'd4, 5'd4, 5'd1, 6'b100010), 32'd3, 1'b0,
         full_exp(32'd3, 1'b1, 5'd4, 2'd1, 1'b0, 32'h2022, RR, 32'd4, 1'b0));

    wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'hFFFF_FFFF;
    step("nop_wb4", 32'd0, 32'd4, 1'b0,
         full_exp(32'd4, 1'b0, 5'd0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0));
    wb_we = 1'b0;

    step("bc_taken", itype(6'b000011, 5'd4, 5'd4, 16'd4), 32'd5, 1'b0, br_exp(1'b1, 32'd9));
    ex_we = 1'b1; ex_rd = 5'd1;
    step("squash1", itype(6'b001000, 5'd1, 5'd5, 16'd1), 32'd6, 1'b0, bubble());
    ex_we = 1'b0;
    step("squash2", 32'hFC00_0000, 32'd7, 1'b0, bubble());

    wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'd3;
    step("bc_not", itype(6'b000011, 5'd4, 5'd4, 16'd4), 32'd7, 1'b0, br_exp(1'b0, 32'd0));
    wb_we = 1'b0;

    mem_we = 1'b1; mem_rd = 5'd5;
    step("addi_neg", itype(6'b001000, 5'd1, 5'd5, 16'hFFFE), 32'd8, 1'b0,
         full_exp(32'd8, 1'b1, 5'd5, 2'd0, 1'b1, 32'hFFFF_FFFE, 32'd4, RR, 1'b0));
    mem_we = 1'b0;

    step("jmp", {6'b000010, 26'd4}, 32'd8, 1'b0, br_exp(1'b1, 32'd4));
    step("squash_j", 32'd0, 32'd9, 1'b0, bubble());

    ins = rtype(5'd4, 5'd4, 5'd1, 6'b100010); ex_we = 1'b1; ex_rd = 5'd4;
    rst = 1'b1;
    #2;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0; ex_we = 1'b0; ex_rd = 5'd0;

    step("mvi_r0", itype(6'b001001, 5'd0, 5'd0, 16'd7), 32'd20, 1'b0,
         full_exp(32'd20, 1'b0, 5'd0, 2'd0, 1'b1, 32'd7, 32'd0, 32'd0, 1'b0));
    step("add_reinit", rtype(5'd6, 5'd1, 5'd4, 6'b100000), 32'd21, 1'b0,
         full_exp(32'd21, 1'b1, 5'd6, 2'd0, 1'b0, 32'h3020, RR, RR, 1'b0));
    step("ill_op", 32'hFC00_0000, 32'd22, 1'b0,
         full_exp(32'd22, 1'b0, 5'd0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1));
    step("ill_funct", 32'h0000_003F, 32'd23, 1'b0,
         full_exp(32'd23, 1'b0, 5'd0, 2'd0, 1'b0, 32'h3F, 32'd0, 32'd0, 1'b1));
    step("nop_after", 32'd0, 32'd24, 1'b0,
         full_exp(32'd24, 1'b0, 5'd0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0));

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
